// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver feeding a scan-code FIFO behind a CPU data/status register pair.
// Define PS2_PARITY_CHECK_EN to enable odd-parity checking and the sticky PERR flag.
module ps2_rx_fifo #(
  parameter int SAMPLE_DELAY = 8,
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 16384
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KB_CLK,
  input  logic       KB_DATA,
  input  logic       CS,
  input  logic       RD,
  input  logic       A0,
  output logic [7:0] D,
  output logic       IRQ,
  output logic       BUSY
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] rs_q, kbc_q, kbd_q;
  logic kbc_prev_q, act_q, busy_q, irq_q, rd_q, ovf_q, perr_q;
  logic [7:0] dly_q, sr_q;
  logic [TW-1:0] to_q;
  logic [2:0] bit_q;
  state_t state_q;
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [7:0] mem [DEPTH];
  logic rst_n, fall, samp, kbd, tmo, rise, pop_req, clr, par_ok;
  logic push, perr_set, full, do_pop, do_push, ovf_set;
  logic [7:0] status, dout;
`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  assign par_ok = ^{sr_q, par_q};
`else
  assign par_ok = 1'b1;
`endif
  // Reset asserts asynchronously but releases only on a clock edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rs_q <= 2'b00;
    else rs_q <= {rs_q[0], 1'b1};
  end
  assign rst_n = rs_q[1];
  assign fall = kbc_prev_q & ~kbc_q[1];
  assign samp = act_q && dly_q == 8'd1;
  assign kbd = kbd_q[1];
  assign tmo = to_q == TW'(TIMEOUT) && state_q != IDLE;
  assign rise = ~rd_q & RD & ~CS;
  assign pop_req = rise & ~A0;
  assign clr = rise & A0;
  assign push = samp && !tmo && state_q == STOP && kbd && par_ok;
  assign perr_set = samp && !tmo && state_q == STOP && !par_ok;
  assign full = cnt_q == (FIFO_AW + 1)'(DEPTH);
  assign do_pop = pop_req && cnt_q != '0;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && !do_push;
  always_comb begin
    cnt_d = do_push == do_pop ? cnt_q : do_push ? cnt_q + (FIFO_AW + 1)'(1) : cnt_q - (FIFO_AW + 1)'(1);
    status = {busy_q, 3'b000, perr_q, ovf_q, full, irq_q};
    dout = A0 ? status : cnt_q != '0 ? mem[rp_q] : 8'h00;
  end
  assign D = rst_n && !CS && !RD ? dout : 8'bzzzz_zzzz;
  assign IRQ = irq_q;
  assign BUSY = busy_q;
  always_ff @(posedge CLK) begin
    if (do_push) mem[wp_q] <= sr_q;
  end
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      kbc_q <= 2'b00;
      kbd_q <= 2'b00;
      kbc_prev_q <= 1'b0;
      dly_q <= '0;
      act_q <= 1'b0;
      to_q <= '0;
      rd_q <= 1'b1;
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      busy_q <= 1'b0;
      bit_q <= '0;
      sr_q <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q <= 1'b0;
`endif
    end else begin
      kbc_q <= {kbc_q[0], KB_CLK};
      kbd_q <= {kbd_q[0], KB_DATA};
      kbc_prev_q <= kbc_q[1];
      dly_q <= fall ? 8'(SAMPLE_DELAY) : act_q ? dly_q - 8'd1 : dly_q;
      act_q <= fall || (act_q && !samp);
      to_q <= fall ? '0 : to_q == TW'(TIMEOUT) ? to_q : to_q + TW'(1);
      rd_q <= RD;
      irq_q <= cnt_q != '0;
      ovf_q <= ovf_set || (ovf_q && !clr);
      perr_q <= perr_set || (perr_q && !clr);
      wp_q <= do_push ? wp_q + FIFO_AW'(1) : wp_q;
      rp_q <= do_pop ? rp_q + FIFO_AW'(1) : rp_q;
      cnt_q <= cnt_d;
      if (tmo) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
      end else if (samp) begin
        case (state_q)
          IDLE: if (!kbd) begin
            state_q <= DATA;
            busy_q <= 1'b1;
            bit_q <= '0;
          end
          DATA: begin
            sr_q <= {kbd, sr_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q <= kbd;
`endif
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed and randomized PS/2 frames checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;
  localparam int SD = 8;
  localparam int AW = 3;
  localparam int TO = 16384;
  localparam int HALF = 20;
  logic clk = 0, rst = 0, kb_clk = 1, kb_data = 1, cs = 1, rd = 1, a0 = 0;
  wire [7:0] d;
  logic irq, busy;
  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  logic ovf_m = 0, perr_m = 0;
  logic irq_a, irq_b, busy_a, busy_mid;
  logic [7:0] b, v;
  logic par, stop;
  int k;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.SAMPLE_DELAY(SD), .FIFO_AW(AW), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .KB_CLK(kb_clk), .KB_DATA(kb_data),
    .CS(cs), .RD(rd), .A0(a0), .D(d), .IRQ(irq), .BUSY(busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits bits of a frame; on the stop bit it can raise RD exactly at the sample edge
  task automatic send_frame(input logic [7:0] fb, input logic fp, input logic fs,
                            input int half, input int nbits, input bit pop_at);
    logic [10:0] bits;
    bits = {fs, fp, fb, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb_data = bits[i];
      tick(half);
      kb_clk = 0;
      if (i == 10) begin
        tick(SD + 2);
        if (pop_at) rd = 1;
        tick(1);
        irq_a = irq;
        busy_a = busy;
        tick(1);
        irq_b = irq;
        tick(half - SD - 4);
      end else begin
        tick(half);
        if (i == 5) busy_mid = busy;
      end
      kb_clk = 1;
    end
    kb_data = 1;
    tick(half);
  endtask

  task automatic rd_reg(input logic sel, output logic [7:0] val);
    cs = 0; a0 = sel; rd = 0;
    @(posedge clk);
    #1 val = d;
    @(negedge clk);
    rd = 1;
    @(negedge clk);
    cs = 1;
    tick(3);
  endtask

  function automatic void m_frame(input logic [7:0] fb, input logic fp, input logic fs);
`ifdef PS2_PARITY_CHECK_EN
    if ((^{fb, fp}) != 1'b1) begin
      perr_m = 1;
      return;
    end
`endif
    if (!fs) return;
    if (q.size() == 8) ovf_m = 1;
    else q.push_back(fb);
  endfunction

  task automatic chk_status(input string tag);
    logic [7:0] val;
    rd_reg(1, val);
    check(tag, val, {4'b0000, perr_m, ovf_m, q.size() == 8, q.size() != 0});
    perr_m = 0;
    ovf_m = 0;
  endtask

  task automatic chk_data(input string tag);
    logic [7:0] val, exp;
    rd_reg(0, val);
    exp = q.size() != 0 ? q.pop_front() : 8'h00;
    check(tag, val, exp);
  endtask

  task automatic good_frame(input logic [7:0] fb);
    send_frame(fb, ~^fb, 1, HALF, 11, 0);
    m_frame(fb, ~^fb, 1);
  endtask

  initial begin
    tick(5);
    rst = 1;
    tick(5);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    chk_status("rst_status");
    // Slow single frame with cycle-exact IRQ latency
    send_frame(8'h1C, 1'b0, 1'b1, 800, 11, 0);
    m_frame(8'h1C, 1'b0, 1'b1);
    check("t1_busy_mid", {7'd0, busy_mid}, 8'h01);
    check("t1_busy_end", {7'd0, busy_a}, 8'h00);
    check("t1_irq_early", {7'd0, irq_a}, 8'h00);
    check("t1_irq_late", {7'd0, irq_b}, 8'h01);
    chk_status("t1_status");
    chk_data("t1_data");
    check("t1_irq_after", {7'd0, irq}, 8'h00);
    chk_status("t1_status_empty");
    // Overflow
    for (int i = 1; i <= 9; i++) good_frame(8'(i));
    check("t2_model_ovf", {7'd0, ovf_m}, 8'h01);
    chk_status("t2_status_ovf");
    for (int i = 0; i < 8; i++) chk_data("t2_data");
    chk_status("t2_status_clr");
    // Wrong parity
    send_frame(8'hF0, 1'b0, 1'b1, HALF, 11, 0);
    m_frame(8'hF0, 1'b0, 1'b1);
    chk_status("t3_status");
    while (q.size() != 0) chk_data("t3_data");
    chk_status("t3_status_clr");
    // Mid-frame timeout
    send_frame(8'h5A, ~^8'h5A, 1, HALF, 5, 0);
    check("t4_busy_partial", {7'd0, busy}, 8'h01);
    tick(TO + 10);
    check("t4_busy_timeout", {7'd0, busy}, 8'h00);
    chk_status("t4_status");
    good_frame(8'h5A);
    chk_data("t4_data");
    // Push and pop in the same cycle while full
    for (int i = 1; i <= 8; i++) good_frame(8'(i));
    cs = 0; a0 = 0; rd = 0;
    send_frame(8'h33, ~^8'h33, 1, HALF, 11, 1);
    cs = 1;
    tick(3);
    void'(q.pop_front());
    m_frame(8'h33, ~^8'h33, 1);
    chk_status("t5_status");
    for (int i = 0; i < 8; i++) chk_data("t5_data");
    chk_status("t5_status_clr");
    // Reset during bit 5 of a frame
    good_frame(8'h11);
    tick(3);
    check("t6_irq_pre", {7'd0, irq}, 8'h01);
    send_frame(8'hA5, ~^8'hA5, 1, HALF, 6, 0);
    check("t6_busy_pre", {7'd0, busy}, 8'h01);
    rst = 0;
    #1;
    check("t6_busy_rst", {7'd0, busy}, 8'h00);
    check("t6_irq_rst", {7'd0, irq}, 8'h00);
    q.delete();
    ovf_m = 0;
    perr_m = 0;
    @(negedge clk);
    tick(3);
    rst = 1;
    tick(5);
    for (int i = 0; i < 5; i++) begin
      kb_data = 1;
      tick(HALF);
      kb_clk = 0;
      tick(HALF);
      kb_clk = 1;
    end
    tick(HALF);
    chk_status("t6_status");
    good_frame(8'h3C);
    chk_data("t6_data");
    // Randomized frames and reads against the model
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      k = $urandom_range(0, 7);
      par = ~^b;
      stop = 1;
      if (k == 6) par = ~par;
      if (k == 7) stop = 0;
      send_frame(b, par, stop, HALF, 11, 0);
      m_frame(b, par, stop);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 2) == 0) chk_status("rnd_status");
        else chk_data("rnd_data");
      end
    end
    chk_status("rnd_status_end");
    while (q.size() != 0) chk_data("rnd_drain");
    chk_data("rnd_empty_data");
    chk_status("rnd_status_clr");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver with a scan-code FIFO and a CPU-readable data/status register pair, mapped in the CPLD I/O window. It is the successor to the single-register keyboard latch. Additions over that latch:
- Input synchronisation, full frame validation (start/parity/stop) and a mid-frame timeout.
- A buffered queue of received codes, sticky error flags and an interrupt request.

## Interface
Parameters:
- SAMPLE_DELAY, 8 — CLK cycles from synchronised KB_CLK falling edge to KB_DATA sample; range 1–255.
- FIFO_AW, 3 — FIFO address width; depth = 2**FIFO_AW entries (default 8).
- TIMEOUT, 16384 — CLK cycles without a KB_CLK falling edge before an in-progress frame is aborted.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset; asynchronous, active-low.
- KB_CLK  in  1  PS/2 clock, asynchronous, idle high.
- KB_DATA  in  1  PS/2 data, asynchronous.
- CS  in  1  block select from I/O decode, active-low.
- RD  in  1  CPU read strobe, active-low.
- A0  in  1  register select: 0 = data, 1 = status.
- D  out  8  data bus; driven only while CS=0 and RD=0, high-Z otherwise.
- IRQ  out  1  active-high; 1 while FIFO not empty.
- BUSY  out  1  active-high; 1 while a frame is being received (LED drive).

## Operation
- KB_CLK and KB_DATA each pass through a 2-FF synchroniser. A falling edge is synced KB_CLK going 1→0.
- On each falling edge, a delay counter loads SAMPLE_DELAY and counts down. When it reaches 0, synced KB_DATA is sampled once. A new falling edge before 0 restarts the count.
- Receiver FSM:
  - IDLE: on a sampled 0, go to DATA and set BUSY=1. A sampled 1 is a glitch: stay in IDLE.
  - DATA: 8 samples shifted in LSB first, then go to PARITY.
  - PARITY: one sample, held, then go to STOP.
  - STOP: one sample, then return to IDLE and set BUSY=0. If the stop bit is 1 and the frame is accepted, push the byte into the FIFO. If the stop bit is 0, discard the byte (framing error); no flag is set.
- Timeout: a free-running counter clears on every falling edge. If it reaches TIMEOUT while in any state other than IDLE, the FSM returns to IDLE, clears BUSY and discards the partial byte.
- FIFO: circular buffer with read and write pointers, both FIFO_AW bits wide and wrapping modulo depth, plus an occupancy count 0..depth.
- Data register read (A0=0): D = FIFO head, or 0x00 if empty. The pop happens on the cycle RD rises while CS=0 and A0=0 (RD sampled 0 on the previous cycle). A pop when empty has no effect.
- Status register read (A0=1): bit0 NE (not empty), bit1 FULL, bit2 OVF, bit3 PERR, bit7 BUSY, bits 6..4 = 0.
  - OVF and PERR are sticky.
  - Both clear on the RD rising edge of a status read.
- Overflow: a push while full with no pop in the same cycle drops the new byte and sets OVF.
- Push and pop in the same cycle both take effect; count is unchanged. This also applies when full: the head is popped and the new byte is stored.
- A flag set and a status-read clear in the same cycle: set wins.

## Timing
- Reset (RST=0, asynchronous) forces:
  - FSM to IDLE; pointers, count, shift register, counters and synchronisers to 0.
  - OVF=0, PERR=0, IRQ=0, BUSY=0, D=high-Z.
  - Reset taken mid-frame discards that frame. Reset release is synchronised to CLK.
- Sample point = KB_CLK fall + 2 cycles (sync) + SAMPLE_DELAY cycles.
- Push: the byte is written the cycle after the stop-bit sample. NE and IRQ go to 1 on the following cycle.
- D is combinational from the registered FIFO head and status. It is valid within the same cycle that CS and RD are asserted.
- After a pop, the next head appears on D the cycle after RD rises.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - Odd parity over the 8 data bits plus the parity bit is checked.
  - On mismatch, the byte is discarded even if the stop bit is valid, and PERR is set.
- PS2_PARITY_CHECK_EN undefined:
  - The parity sample is ignored.
  - Every frame with a valid stop bit is pushed.
  - Status bit3 is always 0.

## Test plan
- Scan code 0x1C, odd parity=0, stop=1, KB_CLK period 1600 CLK cycles -> the cycle after the stop-bit sample the FIFO has count=1; IRQ=1 one cycle later. Status reads 0x01; data read returns 0x1C; after RD rises, IRQ=0 and status reads 0x00.
- Send 9 codes 0x01..0x09 with depth 8 and no reads -> status reads 0x07 (NE, FULL, OVF). Data reads return 0x01..0x08 in order. Status then reads 0x00, confirming OVF cleared on read.
- Send 0xF0 with wrong parity bit -> with PS2_PARITY_CHECK_EN: FIFO stays empty and status reads 0x08. Without the macro: 0xF0 is queued and status reads 0x01.
- Send 4 data bits and then hold KB_CLK high for TIMEOUT+10 cycles -> BUSY returns to 0 and the FIFO stays empty. A following full 0x5A frame is received correctly.
- FIFO full (8 entries); a frame completes in the exact cycle a data-read RD rises -> 0x01 is popped, the new byte is stored, count=8 and OVF=0.
- Assert RST during bit 5 of a frame -> all outputs go to their reset values immediately. The rest of that frame is discarded, and the next frame is received correctly.
